// File: rtl/pc_flag_ctrl_pkg.sv
// Shared encodings for the PC/flag controller: ALU opcodes, branch condition codes,
// flag bit positions and controller state.
package pc_flag_ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned CC_W   = 3;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned IMM_W  = 9;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [CC_W-1:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } cond_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pc_flag_ctrl_branch_cond.sv
// Evaluates a B/BR condition code against the latched [N:V:Z] flags.
module pc_flag_ctrl_branch_cond
  import pc_flag_ctrl_pkg::*;
(
  input  logic [CC_W-1:0]   cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              cond_true_o
);

  logic n, v, z;

  assign n = flags_i[FLAG_N];
  assign v = flags_i[FLAG_V];
  assign z = flags_i[FLAG_Z];

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      CC_NE:   cond_true_o = !z;
      CC_EQ:   cond_true_o = z;
      CC_GT:   cond_true_o = !z && !n;
      CC_LT:   cond_true_o = n;
      CC_GE:   cond_true_o = z || (!z && !n);
      CC_LE:   cond_true_o = n || z;
      CC_OV:   cond_true_o = v;
      CC_UN:   cond_true_o = 1'b1;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flag_ctrl.sv
// Owns the PC and the latched ALU flags; resolves B/BR and retires HLT into an
// absorbing halted state that only reset leaves.
module pc_flag_ctrl
  import pc_flag_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic [OP_W-1:0]   Opcode,
  input  logic [FLAG_W-1:0] ALU_Flag,
  input  logic [CC_W-1:0]   Cond,
  input  logic [IMM_W-1:0]  Imm9,
  input  logic [PC_W-1:0]   Br_Reg,
  output logic [PC_W-1:0]   PC,
  output logic [PC_W-1:0]   PC_Plus2,
  output logic [FLAG_W-1:0] Flags,
  output logic              Taken,
  output logic              Halt
);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              halt_q;
  logic              cond_true;
  logic              is_branch;
  logic [PC_W-1:0]   pc_plus2;
  logic [PC_W-1:0]   b_offset;

  pc_flag_ctrl_branch_cond u_branch_cond (
    .cond_i      (Cond),
    .flags_i     (flags_q),
    .cond_true_o (cond_true)
  );

  // Word offset: sign-extend Imm9 and scale by 2 in one concatenation.
  assign b_offset  = {{(PC_W-IMM_W-1){Imm9[IMM_W-1]}}, Imm9, 1'b0};
  assign pc_plus2  = pc_q + PC_W'(2);
  assign is_branch = (Opcode == OP_B) || (Opcode == OP_BR);

  assign Taken    = is_branch && cond_true && (state_q == ST_RUN);
  assign PC_Plus2 = pc_plus2;
  assign PC       = pc_q;
  assign Flags    = flags_q;
  assign Halt     = halt_q;

  always_comb begin
    pc_d = pc_plus2;
    if (Taken && (Opcode == OP_B)) begin
      pc_d = pc_plus2 + b_offset;
    end else if (Taken && (Opcode == OP_BR)) begin
      pc_d = Br_Reg;
    end else if (Opcode == OP_HLT) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    flags_d = flags_q;
    case (Opcode)
      OP_ADD, OP_SUB:                 flags_d = ALU_Flag;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLAG_Z] = ALU_Flag[FLAG_Z];
      default:                        flags_d = flags_q;
    endcase
  end

  // HALTED freezes every register until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flags_q <= '0;
      halt_q  <= 1'b0;
    end else if ((state_q == ST_RUN) && !Stall) begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      if (Opcode == OP_HLT) begin
        state_q <= ST_HALTED;
        halt_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Bench for pc_flag_ctrl: directed scenarios plus random opcode streams checked
// against an arithmetic reference model of PC, flags and halt.
module tb_pc_flag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic [3:0]  Opcode;
  logic [2:0]  ALU_Flag;
  logic [2:0]  Cond;
  logic [8:0]  Imm9;
  logic [15:0] Br_Reg;
  logic [15:0] PC;
  logic [15:0] PC_Plus2;
  logic [2:0]  Flags;
  logic        Taken;
  logic        Halt;

  int checks = 0;
  int errors = 0;

  int   m_pc;
  logic m_n, m_v, m_z, m_halt;

  always #5 clk = ~clk;

  pc_flag_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .Stall    (Stall),
    .Opcode   (Opcode),
    .ALU_Flag (ALU_Flag),
    .Cond     (Cond),
    .Imm9     (Imm9),
    .Br_Reg   (Br_Reg),
    .PC       (PC),
    .PC_Plus2 (PC_Plus2),
    .Flags    (Flags),
    .Taken    (Taken),
    .Halt     (Halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_cond(input logic [2:0] c);
    case (c)
      3'd0:    return !m_z;
      3'd1:    return m_z;
      3'd2:    return !m_z && !m_n;
      3'd3:    return m_n;
      3'd4:    return m_z || (!m_z && !m_n);
      3'd5:    return m_n || m_z;
      3'd6:    return m_v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_pc"}, 32'(PC), 32'(m_pc));
    check({tag, "_flags"}, 32'(Flags), 32'({m_n, m_v, m_z}));
    check({tag, "_halt"}, 32'(Halt), 32'(m_halt));
  endtask

  // Drive one instruction, check comb outputs, clock it, update model, check registers.
  task automatic step(input logic [3:0] op, input logic st, input logic [2:0] af,
                      input logic [2:0] cc, input logic [8:0] imm, input logic [15:0] br);
    logic tk;
    Opcode = op; Stall = st; ALU_Flag = af; Cond = cc; Imm9 = imm; Br_Reg = br;
    #1;
    tk = !m_halt && (op == 4'hC || op == 4'hD) && m_cond(cc);
    check("taken", 32'(Taken), 32'(tk));
    check("pc_plus2", 32'(PC_Plus2), 32'((m_pc + 2) % 65536));
    @(posedge clk);
    if (!m_halt && !st) begin
      case (op)
        4'h0, 4'h1:             {m_n, m_v, m_z} = af;
        4'h2, 4'h4, 4'h5, 4'h6: m_z = af[0];
        default: ;
      endcase
      if (op == 4'hC && tk)      m_pc = (m_pc + 2 + 2 * int'($signed(imm))) & 32'hFFFF;
      else if (op == 4'hD && tk) m_pc = int'(br);
      else if (op == 4'hF)       m_halt = 1'b1;
      else                       m_pc = (m_pc + 2) & 32'hFFFF;
    end
    #1;
    check_regs("step");
  endtask

  task automatic op_step(input logic [3:0] op, input logic [2:0] af);
    step(op, 1'b0, af, 3'b000, 9'h000, 16'h0000);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    m_pc = 0; m_n = 0; m_v = 0; m_z = 0; m_halt = 0;
    check_regs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset, then advance PC by 2*n with ADDs; the last ADD writes the given flags.
  task automatic setup(input int n, input logic [2:0] fl);
    do_reset();
    repeat (n - 1) op_step(4'h0, 3'b000);
    op_step(4'h0, fl);
  endtask

  initial begin
    rst = 1'b1; Stall = 0; Opcode = 0; ALU_Flag = 0; Cond = 0; Imm9 = 0; Br_Reg = 0;
    m_pc = 0; m_n = 0; m_v = 0; m_z = 0; m_halt = 0;
    #3;
    check_regs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset while halted at PC=0x40.
    repeat (32) op_step(4'h0, 3'b000);
    op_step(4'hF, 3'b000);
    check("t1_pc_pre", 32'(PC), 32'h0040);
    check("t1_halt_pre", 32'(Halt), 32'd1);
    do_reset();
    check("t1_pc_post", 32'(PC), 32'h0000);
    check("t1_halt_post", 32'(Halt), 32'd0);

    // SUB writes all flags; XOR only Z.
    op_step(4'h1, 3'b101);
    check("t2_sub", 32'(Flags), 32'b101);
    op_step(4'h2, 3'b000);
    check("t2_xor", 32'(Flags), 32'b100);

    // B EQ backward taken, then B NE not taken from the same state.
    setup(8, 3'b001);
    step(4'hC, 1'b0, 3'b111, 3'b001, 9'h1FE, 16'h0000);
    check("t3_b_taken", 32'(PC), 32'h000E);
    setup(8, 3'b001);
    step(4'hC, 1'b0, 3'b111, 3'b000, 9'h1FE, 16'h0000);
    check("t3_b_fall", 32'(PC), 32'h0012);

    // BR OV taken, then BR UN with clear flags.
    setup(1, 3'b010);
    step(4'hD, 1'b0, 3'b000, 3'b110, 9'h000, 16'h1234);
    check("t4_br_ov", 32'(PC), 32'h1234);
    op_step(4'h0, 3'b000);
    step(4'hD, 1'b0, 3'b000, 3'b111, 9'h000, 16'h0BEE);
    check("t4_br_un", 32'(PC), 32'h0BEE);

    // Stalled HLT does nothing; real HLT freezes PC through later ADDs.
    setup(3, 3'b000);
    step(4'hF, 1'b1, 3'b000, 3'b000, 9'h000, 16'h0000);
    check("t5_stall_hlt", 32'(Halt), 32'd0);
    check("t5_stall_pc", 32'(PC), 32'h0006);
    op_step(4'hF, 3'b000);
    check("t5_halt", 32'(Halt), 32'd1);
    for (int i = 0; i < 10; i++) op_step(4'h0, 3'b111);
    check("t5_frozen_pc", 32'(PC), 32'h0006);
    check("t5_frozen_flags", 32'(Flags), 32'b000);

    // PC wrap-around and non-flag-writing opcodes.
    do_reset();
    step(4'hD, 1'b0, 3'b000, 3'b111, 9'h000, 16'hFFFE);
    check("t6_pc_fffe", 32'(PC), 32'hFFFE);
    check("t6_plus2_wrap", 32'(PC_Plus2), 32'h0000);
    op_step(4'h0, 3'b010);
    check("t6_wrap", 32'(PC), 32'h0000);
    op_step(4'h8, 3'b111);
    op_step(4'h9, 3'b111);
    op_step(4'hA, 3'b111);
    op_step(4'hB, 3'b111);
    check("t6_flags_kept", 32'(Flags), 32'b010);

    // Random instruction stream with occasional stalls, halts and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 99) == 0) do_reset();
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hE;
      step(op, ($urandom_range(0, 4) == 0), 3'($urandom), 3'($urandom),
           9'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
